tcdm_rdata_collector: RTL and testbench

//  Downstream companion of the eFPGA TCDM read-burst FSM. Snoops the same TCDM port 0
//  (req/gnt/r_valid/r_rdata) and captures each returned read beat into a small buffer.

---
 rtl/tcdm_test_pkg.sv | 23 ++
 rtl/tcdm_rdata_buf.sv | 30 +++
 rtl/tcdm_rdata_collector.sv | 141 ++++++++++++++
 tb/tb_tcdm_rdata_collector.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcdm_test_pkg.sv
// Shared definitions for the TCDM read-data collector.
//  - state_e        : collector FSM states
//  - REG_*          : APB register word indices
//  - ST_*           : bit positions inside the STATUS register
package tcdm_test_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DONE    = 2'd2
   } state_e;

   localparam int REG_STATUS = 0;
   localparam int REG_SIG    = 1;
   localparam int REG_INDEX  = 2;
   localparam int REG_DATA   = 3;

   localparam int ST_DONE    = 0;
   localparam int ST_SPUR    = 1;
   localparam int ST_OVF     = 2;
   localparam int ST_PTR_LSB = 8;

endpackage

// File: rtl/tcdm_rdata_buf.sv
// Capture buffer: NUM_WORDS x DATA_W register file.
//  clk    : clock
//  we     : write enable (synchronous write)
//  waddr  : write index
//  wdata  : write data
//  raddr  : read index (asynchronous read)
//  rdata  : read data
// A write and a read of the same entry in one cycle returns the old value.
module tcdm_rdata_buf #(
   parameter int DATA_W    = 32,
   parameter int NUM_WORDS = 16,
   localparam int IDX_W    = $clog2(NUM_WORDS)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [IDX_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [NUM_WORDS];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/tcdm_rdata_collector.sv
// Snoops TCDM port 0 and captures each returned read beat of a burst.
// Keeps a rotate-XOR signature and sticky protocol error flags, and exposes
// everything over a zero-wait-state APB register window.
//  clk_i / rst_i          : clock, synchronous active-high reset
//  start_i                : burst launch pulse from the burst FSM
//  tcdm_req_i/gnt_i       : snooped request handshake
//  tcdm_r_valid_i/rdata_i : snooped read response
//  apb_*                  : register access (word index addressing)
//  done_o                 : all NUM_WORDS beats captured
//  err_o                  : OR of sticky error flags
module tcdm_rdata_collector
   import tcdm_test_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int NUM_WORDS  = 16,
   parameter int APB_ADDR_W = 3
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic                  tcdm_req_i,
   input  logic                  tcdm_gnt_i,
   input  logic                  tcdm_r_valid_i,
   input  logic [DATA_W-1:0]     tcdm_r_rdata_i,
   input  logic                  apb_psel_i,
   input  logic                  apb_penable_i,
   input  logic                  apb_pwrite_i,
   input  logic [APB_ADDR_W-1:0] apb_paddr_i,
   input  logic [DATA_W-1:0]     apb_pwdata_i,
   output logic [DATA_W-1:0]     apb_prdata_o,
   output logic                  apb_pready_o,
   output logic                  done_o,
   output logic                  err_o
);

   localparam int IDX_W = $clog2(NUM_WORDS);
   localparam int PTR_W = IDX_W + 1;   // must reach NUM_WORDS
   localparam int OUT_W = IDX_W + 4;   // headroom for grants issued before a start

   state_e            state, state_nxt;
   logic [PTR_W-1:0]  wr_ptr;
   logic [OUT_W-1:0]  outstanding;
   logic [DATA_W-1:0] sig;
   logic [IDX_W-1:0]  index;
   logic              err_spur, err_ovf;
   logic [DATA_W-1:0] buf_rdata;

   logic apb_acc, apb_wr, apb_rd, status_wr;
   logic start, err_clr, grant, spur, ovf, store, dec;

   assign apb_acc   = apb_psel_i & apb_penable_i;
   assign apb_wr    = apb_acc & apb_pwrite_i;
   assign apb_rd    = apb_acc & ~apb_pwrite_i;
   assign status_wr = apb_wr & (apb_paddr_i == APB_ADDR_W'(REG_STATUS));

   assign start   = start_i | (status_wr & apb_pwdata_i[0]);
   assign err_clr = status_wr & apb_pwdata_i[1];
   assign grant   = tcdm_req_i & tcdm_gnt_i;

   // A beat coinciding with a start belongs to no burst: dropped silently.
   assign spur  = tcdm_r_valid_i & (state != IDLE) & (outstanding == '0) & ~grant & ~start;
   assign ovf   = tcdm_r_valid_i & (state == DONE) & ~start;
   assign store = tcdm_r_valid_i & (state == COLLECT) & ~start & ~spur;
   // Never underflow: a spurious beat leaves the counter at zero.
   assign dec   = tcdm_r_valid_i & (state != IDLE) & ((outstanding != '0) | grant);

   always_comb begin
      state_nxt = state;
      if (start)
         state_nxt = COLLECT;
      else if (state == COLLECT && store && wr_ptr == PTR_W'(NUM_WORDS-1))
         state_nxt = DONE;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= IDLE;
         wr_ptr      <= '0;
         outstanding <= '0;
         sig         <= '0;
         index       <= '0;
         err_spur    <= 1'b0;
         err_ovf     <= 1'b0;
      end else begin
         state <= state_nxt;
         if (start) begin
            wr_ptr      <= '0;
            outstanding <= '0;
            sig         <= '0;
         end else begin
            outstanding <= outstanding + OUT_W'(grant) - OUT_W'(dec);
            if (store) begin
               wr_ptr <= wr_ptr + 1'b1;
               sig    <= {sig[DATA_W-2:0], sig[DATA_W-1]} ^ tcdm_r_rdata_i;
            end
         end
         // A new error in the clearing cycle wins over the clear.
         err_spur <= (err_spur & ~err_clr) | spur;
         err_ovf  <= (err_ovf  & ~err_clr) | ovf;
         if (apb_wr && apb_paddr_i == APB_ADDR_W'(REG_INDEX))
            index <= apb_pwdata_i[IDX_W-1:0];
         else if (apb_rd && apb_paddr_i == APB_ADDR_W'(REG_DATA))
            index <= index + 1'b1;   // power-of-2 depth wraps for free
      end
   end

   tcdm_rdata_buf #(
      .DATA_W    (DATA_W),
      .NUM_WORDS (NUM_WORDS)
   ) u_buf (
      .clk   (clk_i),
      .we    (store),
      .waddr (wr_ptr[IDX_W-1:0]),
      .wdata (tcdm_r_rdata_i),
      .raddr (index),
      .rdata (buf_rdata)
   );

   always_comb begin
      apb_prdata_o = '0;
      if (apb_rd) begin
         case (apb_paddr_i)
            APB_ADDR_W'(REG_STATUS): begin
               apb_prdata_o[ST_DONE]               = (state == DONE);
               apb_prdata_o[ST_SPUR]               = err_spur;
               apb_prdata_o[ST_OVF]                = err_ovf;
               apb_prdata_o[ST_PTR_LSB +: PTR_W]   = wr_ptr;
            end
            APB_ADDR_W'(REG_SIG):   apb_prdata_o = sig;
            APB_ADDR_W'(REG_INDEX): apb_prdata_o[IDX_W-1:0] = index;
            APB_ADDR_W'(REG_DATA):  apb_prdata_o = buf_rdata;
            default:                apb_prdata_o = '0;
         endcase
      end
   end

   assign apb_pready_o = 1'b1;
   assign done_o       = (state == DONE);
   assign err_o        = err_spur | err_ovf;

endmodule

// File: tb/tb_tcdm_rdata_collector.sv
module tb_tcdm_rdata_collector;
   localparam int DW = 32;
   localparam int NW = 16;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1, start = 1'b0, req = 1'b0, gnt = 1'b0, rv = 1'b0;
   logic [DW-1:0] rdata = '0;
   logic          psel = 1'b0, pen = 1'b0, pwr = 1'b0;
   logic [AW-1:0] paddr = '0;
   logic [DW-1:0] pwdata = '0;
   logic [DW-1:0] prdata;
   logic          pready, done, err;

   int errors = 0;
   int checks = 0;

   tcdm_rdata_collector #(.DATA_W(DW), .NUM_WORDS(NW), .APB_ADDR_W(AW)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .start_i        (start),
      .tcdm_req_i     (req),
      .tcdm_gnt_i     (gnt),
      .tcdm_r_valid_i (rv),
      .tcdm_r_rdata_i (rdata),
      .apb_psel_i     (psel),
      .apb_penable_i  (pen),
      .apb_pwrite_i   (pwr),
      .apb_paddr_i    (paddr),
      .apb_pwdata_i   (pwdata),
      .apb_prdata_o   (prdata),
      .apb_pready_o   (pready),
      .done_o         (done),
      .err_o          (err)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Burst state: 0 idle, 1 collecting, 2 complete.
   int            m_state = 0;
   logic [DW-1:0] m_buf [NW];
   bit            m_wr  [NW];
   int            m_ptr = 0, m_out = 0, m_idx = 0;
   logic [DW-1:0] m_sig = '0;
   bit            m_spur = 0, m_ovf = 0;

   function automatic logic [DW-1:0] rotl1(input logic [DW-1:0] v);
      return {v[DW-2:0], v[DW-1]};
   endfunction

   function automatic logic [DW-1:0] m_read();
      if (!(psel && pen && !pwr)) return '0;
      case (int'(paddr))
         0: return 32'(m_ptr << 8) | 32'(m_ovf) << 2 | 32'(m_spur) << 1 | 32'(m_state == 2);
         1: return m_sig;
         2: return 32'(m_idx);
         3: return m_wr[m_idx] ? m_buf[m_idx] : prdata;  // unwritten entries are undefined
         default: return '0;
      endcase
   endfunction

   task automatic model_step();
      bit acc, wr, rd, st, clr, inc, spur, ovf, store, dec;
      if (rst) begin
         m_state = 0; m_ptr = 0; m_out = 0; m_idx = 0; m_sig = '0;
         m_spur = 0; m_ovf = 0;
         return;
      end
      acc   = psel && pen;
      wr    = acc && pwr;
      rd    = acc && !pwr;
      st    = start || (wr && paddr == 0 && pwdata[0]);
      clr   = wr && paddr == 0 && pwdata[1];
      inc   = req && gnt;
      spur  = rv && m_state != 0 && m_out == 0 && !inc && !st;
      ovf   = rv && m_state == 2 && !st;
      store = rv && m_state == 1 && !st && !spur;
      dec   = rv && m_state != 0 && (m_out != 0 || inc);
      if (wr && paddr == 2) m_idx = int'(pwdata % NW);
      else if (rd && paddr == 3) m_idx = (m_idx + 1) % NW;
      m_spur = (m_spur && !clr) || spur;
      m_ovf  = (m_ovf  && !clr) || ovf;
      if (st) begin
         m_state = 1; m_ptr = 0; m_out = 0; m_sig = '0;
      end else begin
         m_out = m_out + int'(inc) - int'(dec);
         if (store) begin
            m_buf[m_ptr] = rdata;
            m_wr[m_ptr]  = 1;
            m_sig        = rotl1(m_sig) ^ rdata;
            m_ptr++;
            if (m_ptr == NW) m_state = 2;
         end
      end
   endtask

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle_in();
      start = 0; req = 0; gnt = 0; rv = 0;
      psel = 0; pen = 0; pwr = 0;
   endtask

   task automatic apb_wr(input int a, input logic [DW-1:0] d);
      psel = 1; pen = 1; pwr = 1; paddr = AW'(a); pwdata = d;
      tick();
      psel = 0; pen = 0; pwr = 0;
   endtask

   task automatic apb_rd(input int a, input logic [DW-1:0] exp, input string name);
      psel = 1; pen = 1; pwr = 0; paddr = AW'(a);
      #1;
      chk(name, prdata, exp);
      chk({name, "_model"}, prdata, m_read());
      tick();
      psel = 0; pen = 0;
   endtask

   typedef struct {
      int            addr;
      logic [DW-1:0] exp;
      string         name;
   } vec_t;

   vec_t          tv [6];
   logic [DW-1:0] sig_exp, s5;

   initial begin
      sig_exp = '0;
      for (int i = 0; i < NW; i++) sig_exp = rotl1(sig_exp) ^ 32'(i);
      tv[0] = '{0, 32'h0000_1001, "status_after_burst"};
      tv[1] = '{1, sig_exp,       "sig_after_burst"};
      tv[2] = '{2, 32'd0,         "index_reset"};
      tv[3] = '{3, 32'd0,         "data0"};
      tv[4] = '{3, 32'd1,         "data1"};
      tv[5] = '{2, 32'd2,         "index_postinc"};

      // reset
      idle_in();
      rst = 1; tick(); tick(); rst = 0;
      #1;
      chk("reset_done", 32'(done), 0);
      chk("reset_err", 32'(err), 0);
      chk("reset_prdata_idle", prdata, 0);
      apb_rd(0, 0, "reset_status");

      // test 1: 16 grants, each answered next cycle with data 0..15
      start = 1; tick(); start = 0;
      for (int i = 0; i <= NW; i++) begin
         req = (i < NW); gnt = (i < NW); rv = (i > 0); rdata = 32'(i - 1);
         tick();
      end
      idle_in();
      #1;
      chk("t1_done", 32'(done), 1);
      chk("t1_err", 32'(err), 0);
      for (int i = 0; i < 6; i++) apb_rd(tv[i].addr, tv[i].exp, tv[i].name);

      // test 2: index wrap
      apb_wr(2, 32'hFFFF_FFF0 | 32'd14);   // upper bits ignored
      apb_rd(3, 14, "t2_data14");
      apb_rd(3, 15, "t2_data15");
      apb_rd(3, 0,  "t2_data_wrap");

      // test 3: overflow beat in DONE
      rv = 1; rdata = 32'hDEAD_BEEF; tick(); rv = 0;
      #1;
      chk("t3_err", 32'(err), 1);
      apb_rd(0, 32'h0000_1007, "t3_status");
      apb_rd(1, sig_exp, "t3_sig_unchanged");
      apb_wr(2, 0);
      apb_rd(3, 0, "t3_buf0_unchanged");
      apb_wr(0, 32'h2);
      #1;
      chk("t3_err_cleared", 32'(err), 0);
      apb_rd(0, 32'h0000_1001, "t3_status_cleared");

      // test 4: spurious beat in COLLECT
      start = 1; tick(); start = 0;
      rv = 1; rdata = 32'h1234; tick(); rv = 0;
      #1;
      chk("t4_err", 32'(err), 1);
      apb_rd(0, 32'h0000_0002, "t4_status");
      apb_wr(0, 32'h2);

      // test 5: restart mid-burst, beat coinciding with start dropped
      s5 = '0;
      for (int i = 0; i < 5; i++) begin
         req = 1; gnt = 1; rv = 1; rdata = 32'h100 + 32'(i);
         s5 = rotl1(s5) ^ rdata;
         tick();
      end
      idle_in();
      apb_rd(0, 32'h0000_0500, "t5_ptr5");
      apb_rd(1, s5, "t5_sig5");
      start = 1; rv = 1; rdata = 32'hBAD; tick(); idle_in();
      apb_rd(0, 0, "t5_status_restart");
      apb_rd(1, 0, "t5_sig_restart");
      apb_wr(2, 0);
      apb_rd(3, 32'h100, "t5_dropped_beat");
      req = 1; gnt = 1; rv = 1; rdata = 32'h200; tick(); idle_in();
      apb_rd(0, 32'h0000_0100, "t5_ptr1");
      apb_wr(2, 0);
      apb_rd(3, 32'h200, "t5_new_beat");

      // test 6: reset mid-COLLECT with an error pending
      rv = 1; rdata = 32'h55; tick(); rv = 0;
      #1;
      chk("t6_err_before", 32'(err), 1);
      rst = 1; tick(); rst = 0;
      #1;
      chk("t6_done", 32'(done), 0);
      chk("t6_err", 32'(err), 0);
      apb_rd(0, 0, "t6_status");
      apb_rd(1, 0, "t6_sig");
      chk("pready", 32'(pready), 1);

      // randomized run against the model
      for (int c = 0; c < 3000; c++) begin
         bit acc;
         rst   = ($urandom_range(0, 499) == 0);
         start = ($urandom_range(0, 39) == 0);
         req   = 1'($urandom);
         gnt   = 1'($urandom);
         rv    = ($urandom_range(0, 2) != 0);
         rdata = $urandom;
         acc   = ($urandom_range(0, 3) == 0);
         psel  = acc | 1'($urandom);
         pen   = acc;
         pwr   = 1'($urandom);
         paddr = AW'($urandom_range(0, 7));
         pwdata = $urandom;
         if (paddr == 0) pwdata[0] = ($urandom_range(0, 7) == 0);
         #1;
         chk("rnd_done", 32'(done), 32'(m_state == 2));
         chk("rnd_err", 32'(err), 32'(m_spur | m_ovf));
         chk("rnd_prdata", prdata, m_read());
         tick();
      end
      idle_in();
      rst = 0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
